pn_code_gen: RTL and testbench
==============================

PN_CODE_GEN -- requirements
Module: pn_code_gen

Interface
REQ-001 Parameter LFSR_LEN, default 10: LFSR degree in bits, range 3..32.
REQ-002 Parameter TAPS, default 10'b0000001001: feedback mask; bit i set means lfsr[i] enters the feedback XOR (x^10+x^3+1).
REQ-003 Parameter SEED, default 10'h001: power-up seed; also substitutes any all-zero seed load.
REQ-004 Parameter CODE_LEN, default 1023: chips per code period, range 2..2^LFSR_LEN-1.
REQ-005 Parameter ADDR_WIDTH, default 10: width of chip_idx; 2^ADDR_WIDTH >= CODE_LEN.
REQ-006 Parameter AMP_WIDTH, default 8: width of the signed BPSK symbol output.
REQ-007 clk  input  1  system clock; all logic on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 ena  input  1  chip strobe; one chip produced per clk cycle with ena=1.
REQ-010 load  input  1  seed load and period restart request.
REQ-011 seed_in  input  LFSR_LEN  seed value sampled when load=1.
REQ-012 data_out  output  1  current chip bit.
REQ-013 sym_out  output  AMP_WIDTH  signed BPSK symbol of the current chip.
REQ-014 valid_out  output  1  data_out/sym_out/chip_idx valid this cycle.
REQ-015 epoch_out  output  1  high with the first chip of each code period.
REQ-016 chip_idx  output  ADDR_WIDTH  index of the current chip within its period, 0..CODE_LEN-1.

Function
REQ-017 State: lfsr[LFSR_LEN-1:0], seed_reg[LFSR_LEN-1:0], cnt[ADDR_WIDTH-1:0]; all outputs registered.
REQ-018 Feedback fb = XOR-reduce(lfsr & TAPS); advance = {fb, lfsr[LFSR_LEN-1:1]} (right shift, fb into MSB).
REQ-019 Chip cycle (ena=1, load=0): data_out<=lfsr[0], chip_idx<=cnt, epoch_out<=(cnt==0), valid_out<=1; one-cycle latency from ena to valid_out.
REQ-020 Same cycle: if cnt==CODE_LEN-1 then lfsr<=seed_reg and cnt<=0, else lfsr<=advance and cnt<=cnt+1.
REQ-021 ena=0, load=0: lfsr, cnt, data_out, sym_out, chip_idx hold; valid_out<=0, epoch_out<=0.
REQ-022 load=1 (priority over ena): seed_reg<=S and lfsr<=S where S=seed_in, or SEED if seed_in==0; cnt<=0; valid_out<=0, epoch_out<=0; no chip emitted that cycle.
REQ-023 The chip after a load is seed bit 0 with epoch_out=1, chip_idx=0.
REQ-024 sym_out mapping: chip 0 -> +(2^(AMP_WIDTH-1)-1); chip 1 -> -(2^(AMP_WIDTH-1)-1); default widths give +127 / -127 (8'h7F / 8'h81).
REQ-025 sym_out updates in the same cycle as data_out, consistent with it at all times.
REQ-026 lfsr never reaches all-zero: reset and zero-seed substitution guarantee a nonzero state.
REQ-027 CODE_LEN < 2^LFSR_LEN-1 yields a truncated code restarting from seed_reg every CODE_LEN chips.
REQ-028 Back-to-back ena over the period boundary emits chip CODE_LEN-1 then chip 0 (epoch_out=1) on consecutive cycles, no gap.

Reset
REQ-029 rst_n=0 asynchronously sets lfsr<=SEED, seed_reg<=SEED, cnt<=0, data_out<=0, sym_out<=0, valid_out<=0, epoch_out<=0, chip_idx<=0.
REQ-030 rst_n deasserted mid-period restarts the code from SEED at chip 0; first chip after reset has epoch_out=1.
REQ-031 rst_n deassertion with ena=1 in the same edge produces the first chip on that edge, valid_out=1 one cycle later.

Verification
REQ-032 Reset then ena=1 for 1023 cycles, defaults -> first data_out=1 (seed 0x001) with epoch_out=1, chip_idx=0; period contains 512 ones, 511 zeros; no repeat of LFSR state within the period.
REQ-033 Continue ena for 2046 more chips -> exact repeat of first period; epoch_out pulses every 1023 valid chips; chip_idx wraps 1022 -> 0.
REQ-034 Random ena gaps (~50% duty) -> valid_out high exactly one cycle after each ena cycle; chip sequence identical to gapless run; outputs hold during gaps.
REQ-035 load=1 with seed_in=0x155 mid-period, ena=1 same cycle -> no valid that cycle; next chip data_out=1, chip_idx=0, epoch_out=1; subsequent period restarts from 0x155.
REQ-036 load=1 with seed_in=0 -> behaviour identical to load of 0x001 (SEED); LFSR never all-zero.
REQ-037 CODE_LEN=7, LFSR_LEN=3, TAPS=3'b011, SEED=3'b001 -> chip_idx cycles 0..6, epoch every 7 chips, sym_out toggles +127/-127 with data_out; rst_n pulse mid-run -> outputs 0 immediately, restart at chip 0.

Source files
------------

// File: rtl/pn_code_gen.sv
// PN chip generator: Fibonacci LFSR spreading code with period restart, BPSK symbol map.
// Latency: one clk from an ena strobe to the registered chip (valid_out); load takes one clk, emits nothing.
// No backpressure: ena paces the chips, and every output holds its last chip between strobes.
module pn_code_gen #(
  parameter int unsigned         LFSR_LEN   = 10,
  parameter logic [LFSR_LEN-1:0] TAPS       = 10'b0000001001,
  parameter logic [LFSR_LEN-1:0] SEED       = 10'h001,
  parameter int unsigned         CODE_LEN   = 1023,
  parameter int unsigned         ADDR_WIDTH = 10,
  parameter int unsigned         AMP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [LFSR_LEN-1:0]   seed_in,
  output logic                  data_out,
  output logic [AMP_WIDTH-1:0]  sym_out,
  output logic                  valid_out,
  output logic                  epoch_out,
  output logic [ADDR_WIDTH-1:0] chip_idx
);

  // Last chip index of a period; reaching it reloads the LFSR from seed_reg.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CODE_LEN - 1);
  // Symmetric BPSK levels: chip 0 -> +max, chip 1 -> -max (never the asymmetric most-negative code).
  localparam int                    SYM_MAG  = (2 ** (AMP_WIDTH - 1)) - 1;
  localparam logic [AMP_WIDTH-1:0]  SYM_POS  = AMP_WIDTH'(SYM_MAG);
  localparam logic [AMP_WIDTH-1:0]  SYM_NEG  = AMP_WIDTH'(-SYM_MAG);

  logic [LFSR_LEN-1:0]   lfsr;
  logic [LFSR_LEN-1:0]   seed_reg;
  logic [ADDR_WIDTH-1:0] cnt;

  logic                  fb;
  logic [LFSR_LEN-1:0]   lfsr_adv;
  logic [LFSR_LEN-1:0]   load_seed;
  logic                  at_last;

  // Next LFSR state, the zero-protected seed to load, and the end-of-period flag.
  always_comb begin
    fb        = ^(lfsr & TAPS);
    lfsr_adv  = {fb, lfsr[LFSR_LEN-1:1]};
    // An all-zero LFSR would lock up, so a zero seed request falls back to SEED.
    load_seed = (seed_in == '0) ? SEED : seed_in;
    at_last   = (cnt == LAST_IDX);
  end

  // Generator state and registered outputs; load has priority over ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      seed_reg  <= SEED;
      cnt       <= '0;
      data_out  <= 1'b0;
      sym_out   <= '0;
      valid_out <= 1'b0;
      epoch_out <= 1'b0;
      chip_idx  <= '0;
    end else if (load) begin
      seed_reg  <= load_seed;
      lfsr      <= load_seed;
      cnt       <= '0;
      valid_out <= 1'b0;
      epoch_out <= 1'b0;
    end else if (ena) begin
      data_out  <= lfsr[0];
      sym_out   <= lfsr[0] ? SYM_NEG : SYM_POS;
      chip_idx  <= cnt;
      epoch_out <= (cnt == '0);
      valid_out <= 1'b1;
      // Truncated codes restart from the stored seed rather than running the full m-sequence.
      if (at_last) begin
        lfsr <= seed_reg;
        cnt  <= '0;
      end else begin
        lfsr <= lfsr_adv;
        cnt  <= cnt + ADDR_WIDTH'(1);
      end
    end else begin
      valid_out <= 1'b0;
      epoch_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pn_code_gen.sv
// Bench for pn_code_gen: default 10-bit m-sequence instance plus a 3-bit/7-chip instance.
// Reference is a chip-sequence recurrence s[n+L] = XOR(taps . s[n..n+L-1]) indexed by chip number.
// Random ena gaps, seed loads (incl. zero) and async reset pulses are applied to both.
module tb_pn_code_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ena_a, load_a, ena_b, load_b;
  logic [9:0] seed_a;
  logic [2:0] seed_b;

  logic       data_a, valid_a, epoch_a;
  logic [7:0] sym_a;
  logic [9:0] idx_a;
  logic       data_b, valid_b, epoch_b;
  logic [7:0] sym_b;
  logic [2:0] idx_b;

  pn_code_gen dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .load(load_a), .seed_in(seed_a),
    .data_out(data_a), .sym_out(sym_a), .valid_out(valid_a),
    .epoch_out(epoch_a), .chip_idx(idx_a)
  );

  pn_code_gen #(
    .LFSR_LEN(3), .TAPS(3'b011), .SEED(3'b001), .CODE_LEN(7),
    .ADDR_WIDTH(3), .AMP_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .load(load_b), .seed_in(seed_b),
    .data_out(data_b), .sym_out(sym_b), .valid_out(valid_b),
    .epoch_out(epoch_b), .chip_idx(idx_b)
  );

  // Reference model parameters per instance (0 = default, 1 = small)
  int unsigned p_len  [2] = '{10, 3};
  int unsigned p_taps [2] = '{32'h009, 32'h3};
  int unsigned p_seed [2] = '{1, 1};
  int unsigned p_code [2] = '{1023, 7};

  int unsigned cur_seed [2];
  int unsigned kk       [2];
  int unsigned e_data   [2];
  int unsigned e_sym    [2];
  int unsigned e_valid  [2];
  int unsigned e_epoch  [2];
  int unsigned e_idx    [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Chip k of the sequence started from 'seed', by the linear recurrence.
  function automatic bit seq_bit(input int unsigned seed, input int unsigned taps,
                                 input int unsigned len, input int unsigned k);
    bit s [0:1100];
    bit x;
    for (int i = 0; i < int'(len); i++) s[i] = seed[i];
    for (int n = 0; n + int'(len) <= int'(k); n++) begin
      x = 1'b0;
      for (int i = 0; i < int'(len); i++) if (taps[i]) x ^= s[n + i];
      s[n + int'(len)] = x;
    end
    return s[k];
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      cur_seed[u] = p_seed[u];
      kk[u]       = 0;
      e_data[u]   = 0;
      e_sym[u]    = 0;
      e_valid[u]  = 0;
      e_epoch[u]  = 0;
      e_idx[u]    = 0;
    end
  endtask

  task automatic model_step(input int u, input bit e, input bit l, input int unsigned sd);
    int unsigned s;
    bit b;
    if (l) begin
      s = sd & ((32'd1 << p_len[u]) - 1);
      if (s == 0) s = p_seed[u];
      cur_seed[u] = s;
      kk[u]       = 0;
      e_valid[u]  = 0;
      e_epoch[u]  = 0;
    end else if (e) begin
      b          = seq_bit(cur_seed[u], p_taps[u], p_len[u], kk[u]);
      e_data[u]  = b;
      e_sym[u]   = b ? 32'h81 : 32'h7F;
      e_idx[u]   = kk[u];
      e_epoch[u] = (kk[u] == 0);
      e_valid[u] = 1;
      kk[u]      = (kk[u] + 1) % p_code[u];
    end else begin
      e_valid[u] = 0;
      e_epoch[u] = 0;
    end
  endtask

  task automatic check_all();
    chk("a_valid", valid_a, e_valid[0]);
    chk("a_epoch", epoch_a, e_epoch[0]);
    chk("a_data",  data_a,  e_data[0]);
    chk("a_sym",   sym_a,   e_sym[0]);
    chk("a_idx",   idx_a,   e_idx[0]);
    chk("b_valid", valid_b, e_valid[1]);
    chk("b_epoch", epoch_b, e_epoch[1]);
    chk("b_data",  data_b,  e_data[1]);
    chk("b_sym",   sym_b,   e_sym[1]);
    chk("b_idx",   idx_b,   e_idx[1]);
  endtask

  // Called at a negedge: drive, advance the model, check after the posedge, return at next negedge.
  task automatic step(input bit ea, input bit la, input int unsigned sa,
                      input bit eb, input bit lb, input int unsigned sb);
    ena_a  = ea; load_a = la; seed_a = sa[9:0];
    ena_b  = eb; load_b = lb; seed_b = sb[2:0];
    model_step(0, ea, la, sa);
    model_step(1, eb, lb, sb);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 1, 0, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit          chips [0:1022];
  bit          seen  [0:1023];
  int unsigned ones;
  int unsigned distinct;
  int unsigned w;
  int unsigned r;
  int unsigned sa, sb;
  bit          ea, eb, la, lb;

  initial begin
    rst_n = 1'b0;
    ena_a = 0; load_a = 0; seed_a = '0;
    ena_b = 0; load_b = 0; seed_b = '0;
    model_reset();
    #12;
    check_all();

    // Release reset with ena already high: first chip on the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 1023; i++) begin
      step(1, 0, 0, 1, 0, 0);
      chips[i] = data_a;
      ones += data_a;
    end
    chk("period_ones", ones, 512);
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int j = 0; j < 1023; j++) begin
      w = 0;
      for (int i = 0; i < 10; i++) w |= int'(chips[(j + i) % 1023]) << i;
      if (!seen[w]) distinct++;
      seen[w] = 1'b1;
    end
    chk("period_states", distinct, 1023);

    // Two more full periods gapless.
    run(2046);

    // Random ena gaps, occasional loads with zero / 0x155 / random seeds.
    for (int i = 0; i < 2000; i++) begin
      ea = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1));
      la = ($urandom_range(0, 63) == 0);
      lb = ($urandom_range(0, 63) == 0);
      r  = $urandom_range(0, 3);
      sa = (r == 0) ? 0 : (r == 1) ? 32'h155 : ($urandom & 32'h3FF);
      r  = $urandom_range(0, 3);
      sb = (r == 0) ? 0 : ($urandom & 32'h7);
      step(ea, la, sa, eb, lb, sb);
    end

    // Mid-period load of 0x155 with ena high, then past a period boundary.
    run(100);
    step(1, 1, 32'h155, 1, 1, 32'h5);
    chk("load_no_valid", valid_a, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("load_first_data", data_a, 1);
    chk("load_first_epoch", epoch_a, 1);
    chk("load_first_idx", idx_a, 0);
    run(1030);

    // Zero seed behaves like SEED.
    step(1, 1, 0, 1, 1, 0);
    run(1100);

    // Async reset pulse mid-run.
    run(3);
    reset_pulse();
    run(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
